// File: rtl/rotate_pkg.sv
// Shared constants for the tile-level rotate scheduler: FSM encodings, rotation codes, tile geometry.
package rotate_pkg;

  localparam int unsigned TILE_DIM   = 8;
  localparam int unsigned TILE_BYTES = 192;
  localparam int unsigned TILE_SHIFT = $clog2(TILE_DIM);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // A CCW rotation by d is the CW rotation by (4-d) mod 4.
  function automatic logic [1:0] eff_rot(input logic [1:0] deg, input logic dir);
    return (dir == DIR_CCW) ? 2'(3'd4 - 3'(deg)) : deg;
  endfunction

endpackage

// File: rtl/rotate_tile_map.sv
// Combinational source/destination tile index mapping for a clockwise rotation code.
module rotate_tile_map
  import rotate_pkg::*;
#(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [DIM_W-1:0]  row_i,
  input  logic [DIM_W-1:0]  col_i,
  input  logic [DIM_W-1:0]  rows_i,
  input  logic [DIM_W-1:0]  cols_i,
  input  logic [1:0]        eff_i,
  output logic [ADDR_W-1:0] src_idx_o,
  output logic [ADDR_W-1:0] dst_idx_o
);

  logic [ADDR_W-1:0] r, c, rr, cc;
  logic [ADDR_W-1:0] dr, dc, dcw;

  always_comb begin
    r   = ADDR_W'(row_i);
    c   = ADDR_W'(col_i);
    rr  = ADDR_W'(rows_i);
    cc  = ADDR_W'(cols_i);
    dr  = r;
    dc  = c;
    dcw = cc;
    case (eff_i)
      DEG_90: begin
        dr  = c;
        dc  = rr - r - ADDR_W'(1);
        dcw = rr;
      end
      DEG_180: begin
        dr  = rr - r - ADDR_W'(1);
        dc  = cc - c - ADDR_W'(1);
        dcw = cc;
      end
      DEG_270: begin
        dr  = cc - c - ADDR_W'(1);
        dc  = r;
        dcw = rr;
      end
      default: ;
    endcase
    src_idx_o = r * cc + c;
    dst_idx_o = dr * dcw + dc;
  end

endmodule

// File: rtl/rotate_tile_sched.sv
// Frame scheduler walking the image tile by tile and handshaking DMA and the pixel core.
// Optional RUN-state watchdog enabled by defining ROT_TIMEOUT_EN.
module rotate_tile_sched
  import rotate_pkg::*;
#(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned ADDR_W = 32
`ifdef ROT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_START,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [1:0]        I_DEGREES,
  input  logic              I_DIRECTION,
  input  logic              I_DMA_READY,
  input  logic              I_TILE_DONE,
  output logic              O_TILE_START,
  output logic [ADDR_W-1:0] O_SRC_BASE,
  output logic [ADDR_W-1:0] O_DST_BASE,
  output logic [DIM_W-1:0]  O_TILE_ROW,
  output logic [DIM_W-1:0]  O_TILE_COL,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR
);

  function automatic logic [DIM_W-1:0] tiles_of(input logic [DIM_W-1:0] d);
    return (d >> TILE_SHIFT) + DIM_W'(|d[TILE_SHIFT-1:0]);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [1:0]        eff_q, eff_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic              tile_start_q, tile_start_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [DIM_W-1:0]  tile_row_q, tile_row_d, tile_col_q, tile_col_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] src_idx, dst_idx;
  logic              last_tile;

  rotate_tile_map #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_map (
    .row_i     (row_q),
    .col_i     (col_q),
    .rows_i    (rows_q),
    .cols_i    (cols_q),
    .eff_i     (eff_q),
    .src_idx_o (src_idx),
    .dst_idx_o (dst_idx)
  );

  assign last_tile = (row_q == rows_q - DIM_W'(1)) && (col_q == cols_q - DIM_W'(1));

`ifdef ROT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  // Watchdog counts RUN cycles since the most recent ISSUE.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_ISSUE) begin
      tmo_d = '0;
    end else if (state_q == ST_RUN) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    eff_d        = eff_q;
    row_d        = row_q;
    col_d        = col_q;
    tile_start_d = 1'b0;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          state_d = ST_LOAD;
          rows_d  = tiles_of(I_HEIGHT);
          cols_d  = tiles_of(I_WIDTH);
          eff_d   = eff_rot(I_DEGREES, I_DIRECTION);
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        row_d = '0;
        col_d = '0;
        if (rows_q == '0 || cols_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Address/position outputs are captured here so they are valid during ISSUE.
        if (I_DMA_READY) begin
          state_d      = ST_ISSUE;
          tile_start_d = 1'b1;
          src_base_d   = ADDR_W'(src_idx * ADDR_W'(TILE_BYTES));
          dst_base_d   = ADDR_W'(dst_idx * ADDR_W'(TILE_BYTES));
          tile_row_d   = row_q;
          tile_col_d   = col_q;
        end
      end
      ST_ISSUE: state_d = ST_RUN;
      ST_RUN: begin
        if (I_TILE_DONE) begin
          state_d = ST_NEXT;
        end
`ifdef ROT_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_NEXT: begin
        if (last_tile) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          if (col_q == cols_q - DIM_W'(1)) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q      <= ST_IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      eff_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      tile_start_q <= 1'b0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      eff_q        <= eff_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tile_start_q <= tile_start_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign O_TILE_START = tile_start_q;
  assign O_SRC_BASE   = src_base_q;
  assign O_DST_BASE   = dst_base_q;
  assign O_TILE_ROW   = tile_row_q;
  assign O_TILE_COL   = tile_col_q;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_ERR        = err_q;

endmodule

// File: tb/tb_rotate_tile_sched.sv
// Scoreboard bench for rotate_tile_sched: expected tiles queued at frame start, popped on each O_TILE_START.
module tb_rotate_tile_sched;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET_N = 1'b0;
  logic        I_START = 1'b0;
  logic [15:0] I_HEIGHT = '0;
  logic [15:0] I_WIDTH = '0;
  logic [1:0]  I_DEGREES = '0;
  logic        I_DIRECTION = 1'b0;
  logic        I_DMA_READY = 1'b0;
  logic        I_TILE_DONE = 1'b0;
  logic        O_TILE_START;
  logic [31:0] O_SRC_BASE;
  logic [31:0] O_DST_BASE;
  logic [15:0] O_TILE_ROW;
  logic [15:0] O_TILE_COL;
  logic        O_BUSY;
  logic        O_DONE;
  logic        O_ERR;

  rotate_tile_sched #(
    .DIM_W  (16),
    .ADDR_W (32)
`ifdef ROT_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .I_HCLK       (I_HCLK),
    .I_HRESET_N   (I_HRESET_N),
    .I_START      (I_START),
    .I_HEIGHT     (I_HEIGHT),
    .I_WIDTH      (I_WIDTH),
    .I_DEGREES    (I_DEGREES),
    .I_DIRECTION  (I_DIRECTION),
    .I_DMA_READY  (I_DMA_READY),
    .I_TILE_DONE  (I_TILE_DONE),
    .O_TILE_START (O_TILE_START),
    .O_SRC_BASE   (O_SRC_BASE),
    .O_DST_BASE   (O_DST_BASE),
    .O_TILE_ROW   (O_TILE_ROW),
    .O_TILE_COL   (O_TILE_COL),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .O_ERR        (O_ERR)
  );

  always #5 I_HCLK = ~I_HCLK;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] row;
    logic [15:0] col;
  } tile_t;

  tile_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    n_starts, first_k, issue_k, done_k;
  logic  err_seen;

  // Reference tile order and addresses from the rotation table.
  task automatic push_frame(input int h, input int w, input int deg, input int dir);
    int R, C, eff, dr, dc, dcw;
    tile_t t;
    R   = (h + 7) / 8;
    C   = (w + 7) / 8;
    eff = dir ? ((4 - deg) % 4) : deg;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        case (eff)
          1:       begin dr = c;         dc = R - 1 - r; dcw = R; end
          2:       begin dr = R - 1 - r; dc = C - 1 - c; dcw = C; end
          3:       begin dr = C - 1 - c; dc = r;         dcw = R; end
          default: begin dr = r;         dc = c;         dcw = C; end
        endcase
        t.src = 32'((r * C + c) * 192);
        t.dst = 32'((dr * dcw + dc) * 192);
        t.row = 16'(r);
        t.col = 16'(c);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic run_frame(input int h, input int w, input int deg, input int dir,
                           input int dma_hold, input int restart_at, input bit do_done,
                           input int budget);
    int    countdown;
    tile_t e, a;
    I_HEIGHT    = 16'(h);
    I_WIDTH     = 16'(w);
    I_DEGREES   = 2'(deg);
    I_DIRECTION = dir[0];
    I_DMA_READY = (dma_hold == 0);
    I_START     = 1'b1;
    @(negedge I_HCLK);
    I_START   = 1'b0;
    n_starts  = 0;
    first_k   = -1;
    issue_k   = -1;
    done_k    = -1;
    countdown = 0;
    for (int k = 0; k < budget; k++) begin
      if (k == 0) begin
        total++;
        if (O_BUSY !== 1'b1) begin
          bad++;
          $display("FAIL busy_after_start: got %b want 1", O_BUSY);
        end
      end
      if (O_TILE_START) begin
        if (first_k < 0) first_k = k;
        issue_k = k;
        n_starts++;
        total++;
        if (!I_DMA_READY) begin
          bad++;
          $display("FAIL start_without_dma: tile start at k=%0d while DMA low", k);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_tile: unexpected tile start at k=%0d", k);
        end else begin
          e = exp_q.pop_front();
          a = '{src: O_SRC_BASE, dst: O_DST_BASE, row: O_TILE_ROW, col: O_TILE_COL};
          if (a !== e) begin
            bad++;
            $display("FAIL tile_addr: got src=%0d dst=%0d r=%0d c=%0d want src=%0d dst=%0d r=%0d c=%0d",
                     a.src, a.dst, a.row, a.col, e.src, e.dst, e.row, e.col);
          end
        end
        if (do_done) countdown = 5;
      end
      if (O_DONE) begin
        done_k = k;
        break;
      end
      I_TILE_DONE = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) I_TILE_DONE = 1'b1;
      end
      I_DMA_READY = (k + 1 >= dma_hold);
      I_START     = (k == restart_at);
      if (k == restart_at) I_HEIGHT = '0;
      @(negedge I_HCLK);
    end
    I_START     = 1'b0;
    I_TILE_DONE = 1'b0;
    err_seen    = O_ERR;
    total++;
    if (done_k < 0) begin
      bad++;
      $display("FAIL frame_timeout: no O_DONE within %0d cycles", budget);
    end
    @(negedge I_HCLK);
    total++;
    if ({O_DONE, O_BUSY} !== 2'b00) begin
      bad++;
      $display("FAIL done_pulse_end: got done=%b busy=%b want 0 0", O_DONE, O_BUSY);
    end
  endtask

  task automatic check_frame_end(input string name, input int tiles, input logic err);
    total++;
    if (n_starts !== tiles || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_tiles: got %0d starts (%0d unissued) want %0d", name, n_starts, exp_q.size(), tiles);
    end
    total++;
    if (err_seen !== err) begin
      bad++;
      $display("FAIL %s_err: got %b want %b", name, err_seen, err);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({O_TILE_START, O_SRC_BASE, O_DST_BASE, O_TILE_ROW, O_TILE_COL, O_BUSY, O_DONE, O_ERR} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b busy=%b done=%b err=%b src=%0d dst=%0d want all 0",
               O_TILE_START, O_BUSY, O_DONE, O_ERR, O_SRC_BASE, O_DST_BASE);
    end
    repeat (3) @(negedge I_HCLK);
    I_HRESET_N = 1'b1;
    @(negedge I_HCLK);
  endtask

  task automatic test_rot0();
    push_frame(16, 16, 0, 0);
    run_frame(16, 16, 0, 0, 0, -1, 1'b1, 400);
    total++;
    if (first_k !== 2) begin
      bad++;
      $display("FAIL rot0_latency: first start k=%0d want 2", first_k);
    end
    check_frame_end("rot0", 4, 1'b0);
  endtask

  task automatic test_rot90();
    push_frame(16, 24, 1, 0);
    run_frame(16, 24, 1, 0, 0, -1, 1'b1, 400);
    check_frame_end("rot90", 6, 1'b0);
  endtask

  task automatic test_ccw_partial();
    push_frame(8, 16, 1, 1);
    run_frame(8, 16, 1, 1, 0, -1, 1'b1, 400);
    check_frame_end("ccw90", 2, 1'b0);
    push_frame(20, 13, 2, 0);
    run_frame(20, 13, 2, 0, 0, -1, 1'b1, 400);
    check_frame_end("rot180_partial", 6, 1'b0);
    push_frame(17, 9, 3, 0);
    run_frame(17, 9, 3, 0, 0, -1, 1'b1, 400);
    check_frame_end("rot270_partial", 6, 1'b0);
  endtask

  task automatic test_zero_dim();
    run_frame(0, 8, 0, 0, 0, -1, 1'b1, 50);
    total++;
    if (done_k !== 1) begin
      bad++;
      $display("FAIL zero_done_latency: done at k=%0d want 1", done_k);
    end
    check_frame_end("zero_dim", 0, 1'b1);
  endtask

  task automatic test_dma_stall();
    push_frame(16, 8, 0, 1);
    run_frame(16, 8, 0, 1, 20, 10, 1'b1, 400);
    total++;
    if (first_k < 20) begin
      bad++;
      $display("FAIL stall_first_start: first start k=%0d want >=20", first_k);
    end
    check_frame_end("stall", 2, 1'b0);
  endtask

`ifdef ROT_TIMEOUT_EN
  task automatic test_timeout();
    push_frame(16, 16, 0, 0);
    run_frame(16, 16, 0, 0, 0, -1, 1'b0, 200);
    total++;
    if (done_k - issue_k < 16 || done_k - issue_k > 18) begin
      bad++;
      $display("FAIL timeout_latency: done %0d cycles after issue want 16..18", done_k - issue_k);
    end
    check_frame_end("timeout", 1, 1'b1);
  endtask
`endif

  task automatic test_reset_midframe();
    bit seen;
    bit done_during;
    seen = 1'b0;
    done_during = 1'b0;
    I_HEIGHT    = 16'd32;
    I_WIDTH     = 16'd32;
    I_DEGREES   = 2'd1;
    I_DIRECTION = 1'b0;
    I_DMA_READY = 1'b1;
    I_START     = 1'b1;
    @(negedge I_HCLK);
    I_START = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (O_TILE_START) begin
        seen = 1'b1;
        break;
      end
      @(negedge I_HCLK);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midreset_issue: no tile start within 50 cycles");
    end
    repeat (3) @(negedge I_HCLK);
    @(posedge I_HCLK);
    #2 I_HRESET_N = 1'b0;
    #1;
    total++;
    if ({O_TILE_START, O_SRC_BASE, O_DST_BASE, O_TILE_ROW, O_TILE_COL, O_BUSY, O_DONE, O_ERR} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got start=%b busy=%b done=%b err=%b dst=%0d want all 0",
               O_TILE_START, O_BUSY, O_DONE, O_ERR, O_DST_BASE);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge I_HCLK);
      if (O_DONE) done_during = 1'b1;
    end
    I_HRESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge I_HCLK);
      if (O_DONE || O_BUSY || O_TILE_START) done_during = 1'b1;
    end
    total++;
    if (done_during) begin
      bad++;
      $display("FAIL midreset_idle: activity seen after reset, want idle with no O_DONE");
    end
    push_frame(8, 8, 2, 0);
    run_frame(8, 8, 2, 0, 0, -1, 1'b1, 100);
    check_frame_end("after_reset", 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rot0();
    test_rot90();
    test_ccw_partial();
    test_zero_dim();
    test_dma_stall();
`ifdef ROT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
